// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encoding, FSM state, default latencies.
// Imported by mdu_arith and mdu_ctrl.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational product and quotient/remainder for mult/div ops.
// Ports: op, a, b in; prod, quot, rem, div_zero out.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [63:0] a_ext;
  logic [63:0] b_ext;

  assign sgn = (op == OP_MULT) | (op == OP_DIV)
             | (op == OP_MADD);

  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];

  assign a_ext = {{32{a_neg}}, a};
  assign b_ext = {{32{b_neg}}, b};
  assign prod  = a_ext * b_ext;

  // Magnitude divide then re-sign: gives truncation toward zero,
  // remainder follows dividend, and 0x80000000/-1 lands on
  // lo=0x80000000, hi=0 without a special case.
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;

  assign div_zero = (b == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;

  assign q_mag = a_mag / b_safe;
  assign r_mag = a_mag % b_safe;

  assign quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem  = a_neg ? (32'd0 - r_mag) : r_mag;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: issue, cycle counter, HI/LO, md-busy stall term.
// Ports: clk, rst_n, start, op, a, b, md_in_d in; busy, stall_md, done, hi, lo out.
// Build option: define MDU_MADD_EN to enable MADD (op 6) / MADDU (op 7).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_md,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES)
                      ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_t  state_q;
  mdu_state_t  state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic        is_mul;
  logic        is_div;
  logic        is_madd;
  logic        is_multi;
  logic        issue;
  logic        load;
  logic        commit;

  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  logic [63:0] pend_q;
  logic        pend_keep_q;
  logic        pend_acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  mdu_arith u_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_madd = 1'b0;
    unique case (1'b1)
      (op == OP_MULT),
      (op == OP_MULTU): is_mul = 1'b1;
      (op == OP_DIV),
      (op == OP_DIVU):  is_div = 1'b1;
`ifdef MDU_MADD_EN
      (op == OP_MADD),
      (op == OP_MADDU): is_madd = 1'b1;
`endif
      default: ;
    endcase
  end

  assign is_multi = is_mul | is_div | is_madd;
  assign issue    = start & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue && is_multi) begin
          load    = 1'b1;
          state_d = RUN;
          cnt_d   = is_div ? CW'(DIV_CYCLES)
                           : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_keep_q <= 1'b0;
      pend_acc_q  <= 1'b0;
    end else if (load) begin
      pend_q      <= is_div ? {rem, quot} : prod;
      pend_keep_q <= is_div & div_zero;
      pend_acc_q  <= is_madd;
    end
  end

  // Accumulate reads HI/LO at commit, so MTHI/MTLO
  // ahead of a MADD are honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        if (!pend_keep_q) begin
          if (pend_acc_q)
            {hi_q, lo_q} <= {hi_q, lo_q} + pend_q;
          else
            {hi_q, lo_q} <= pend_q;
        end
      end else if (issue && op == OP_MTHI) begin
        hi_q <= a;
      end else if (issue && op == OP_MTLO) begin
        lo_q <= a;
      end
    end
  end

  assign busy     = (issue & is_multi) | (cnt_q != '0);
  assign stall_md = md_in_d & busy;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table plus
// stall, ignored-start, reset-abort and MADD sequences.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] T_MULT  = 3'd0;
  localparam logic [2:0] T_MULTU = 3'd1;
  localparam logic [2:0] T_DIV   = 3'd2;
  localparam logic [2:0] T_DIVU  = 3'd3;
  localparam logic [2:0] T_MTHI  = 3'd4;
  localparam logic [2:0] T_MTLO  = 3'd5;
  localparam logic [2:0] T_MADD  = 3'd6;
  localparam logic [2:0] T_MADDU = 3'd7;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_in_d;
  logic        busy;
  logic        stall_md;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  mdu_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .md_in_d  (md_in_d),
    .busy     (busy),
    .stall_md (stall_md),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] h,
                         input logic [31:0] l);
    @(posedge clk); #1;
    start = 1'b1; op = T_MTHI; a = h;
    @(posedge clk); #1;
    op = T_MTLO; a = l;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mthi", hi, h);
    chk("mtlo", lo, l);
  endtask

  // Cycle 0 is the issue cycle; done expected in cycle n+1.
  // late=1 raises a second start in cycle 2 that must be ignored.
  task automatic run_op(input logic [2:0]  o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input int          n,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input logic        md,
                        input logic        late);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    md_in_d = md;
    for (int c = 0; c <= n + 2; c++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(c <= n));
      chk("done", 32'(done), 32'(c == n + 1));
      chk("stall", 32'(stall_md), 32'(md && c <= n));
      if (c == n + 1) begin
        chk("hi", hi, eh);
        chk("lo", lo, el);
      end
      @(posedge clk); #1;
      start = late && (c == 1);
      if (late && c == 1) begin
        op = T_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      end
    end
    start = 1'b0;
    md_in_d = 1'b0;
  endtask

  initial begin
    vecs[0] = '{T_MULT,  32'hFFFF_FFFD, 32'd7,
                32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{T_DIVU,  32'd100, 32'd7,
                32'h0, 32'h0, 32'd2, 32'd14};
    vecs[3] = '{T_DIV,   32'hFFFF_FFF9, 32'd2,
                32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{T_DIV,   32'h8000_0000, 32'hFFFF_FFFF,
                32'h5, 32'h5, 32'h0, 32'h8000_0000};
    vecs[5] = '{T_DIV,   32'd1234, 32'd0,
                32'h11, 32'h22, 32'h11, 32'h22};
    vecs[6] = '{T_DIVU,  32'd99, 32'd0,
                32'h5, 32'h6, 32'h5, 32'h6};
    vecs[7] = '{T_MULT,  32'h0001_0000, 32'h0001_0000,
                32'h0, 32'h0, 32'h1, 32'h0};
    vecs[8] = '{T_DIV,   32'd7, 32'hFFFF_FFFE,
                32'h0, 32'h0, 32'h1, 32'hFFFF_FFFD};
    vecs[9] = '{T_MULT,  32'h8000_0000, 32'h8000_0000,
                32'h0, 32'h0, 32'h4000_0000, 32'h0};

    rst_n = 1'b0; start = 1'b0; op = '0;
    a = '0; b = '0; md_in_d = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             (vecs[i].op == T_DIV || vecs[i].op == T_DIVU)
               ? DC : MC,
             vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, 1'b0);
    end

    // stall with md_in_d high, plus ignored second start
    run_op(T_MULT, 32'd3, 32'd5, MC, 32'd0, 32'd15,
           1'b1, 1'b1);
    run_op(T_MULT, 32'd4, 32'd5, MC, 32'd0, 32'd20,
           1'b0, 1'b0);

    // reset in cycle 3 of a DIVU
    preload(32'h33, 32'h44);
    @(posedge clk); #1;
    start = 1'b1; op = T_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen_done = 0;
      int seen_busy = 0;
      for (int c = 0; c < DC + 4; c++) begin
        @(negedge clk);
        if (done) seen_done++;
        if (busy) seen_busy++;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      chk("abort_no_busy", 32'(seen_busy), 32'd0);
      chk("abort_hi_hold", hi, 32'd0);
    end
    run_op(T_DIVU, 32'd100, 32'd7, DC, 32'd2, 32'd14,
           1'b0, 1'b0);

`ifdef MDU_MADD_EN
    preload(32'h0, 32'hFFFF_FFFF);
    run_op(T_MADDU, 32'd1, 32'd1, MC, 32'd1, 32'd0,
           1'b0, 1'b0);
    preload(32'h0, 32'd10);
    run_op(T_MADD, 32'hFFFF_FFFF, 32'd3, MC, 32'd0, 32'd7,
           1'b0, 1'b0);
`else
    for (int k = 0; k < 2; k++) begin
      preload(32'h0, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      start = 1'b1; op = (k == 0) ? T_MADDU : T_MADD;
      a = 32'd1; b = 32'd1;
      @(negedge clk);
      chk("undef_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (MC + 2) @(negedge clk);
      chk("undef_busy2", 32'(busy), 32'd0);
      chk("undef_hi", hi, 32'd0);
      chk("undef_lo", lo, 32'hFFFF_FFFF);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
